// File: rtl/if_fetch_pkg.sv
// Shared pipeline definitions for the instruction fetch stage:
// bubble word, default reset vector and the fetch/pc-select enums.
package if_fetch_pkg;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HOLD,
        ST_SQUASH
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_REDIRECT
    } pc_sel_e;

endpackage

// File: rtl/if_pc_gen.sv
// Fetch program counter: register plus hold / +4 / redirect select.
// The +4 wraps modulo 2^32 by construction of the 32-bit adder.
module if_pc_gen
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_sel_e     pc_sel,
    input  logic [31:0] redirect_tgt,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            PC_INC:      pc_d = pc_q + 32'd4;
            PC_REDIRECT: pc_d = redirect_tgt;
            default:     pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Single-outstanding instruction fetch stage with a one-entry output buffer
// toward IF/ID; redirects arriving mid-request squash the in-flight response.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] PC_out,
    output logic        valid_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         valid_q, valid_d;
    logic [31:0]  squash_addr_q, squash_addr_d;
    pc_sel_e      pc_sel;
    logic [31:0]  pc;
    logic [31:0]  redirect_tgt;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    if_pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .pc_sel      (pc_sel),
        .redirect_tgt(redirect_tgt),
        .pc          (pc)
    );

    // Request decoded from state only; SQUASH keeps presenting the abandoned
    // address because pc has already moved to the redirect target.
    assign imem_req  = (state_q != ST_HOLD);
    assign imem_addr = (state_q == ST_SQUASH) ? squash_addr_q : pc;

    always_comb begin
        state_d       = state_q;
        inst_d        = inst_q;
        pc_out_d      = pc_out_q;
        valid_d       = valid_q;
        squash_addr_d = squash_addr_q;
        pc_sel        = PC_HOLD;
        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    pc_sel = PC_REDIRECT;
                    if (!imem_ack) begin
                        state_d       = ST_SQUASH;
                        squash_addr_d = pc;
                    end
                end else if (imem_ack) begin
                    inst_d   = imem_rdata;
                    pc_out_d = pc;
                    valid_d  = 1'b1;
                    pc_sel   = PC_INC;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_sel  = PC_REDIRECT;
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                    state_d = ST_FETCH;
                end else if (valid_q && !stall) begin
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                    state_d = ST_FETCH;
                end
            end
            ST_SQUASH: begin
                // Late redirects only retarget pc; the stale response is still awaited.
                if (redirect) begin
                    pc_sel = PC_REDIRECT;
                end
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            inst_q        <= NOP_INST;
            pc_out_q      <= 32'h0000_0000;
            valid_q       <= 1'b0;
            squash_addr_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            inst_q        <= inst_d;
            pc_out_q      <= pc_out_d;
            valid_q       <= valid_d;
            squash_addr_q <= squash_addr_d;
        end
    end

    assign inst_out  = inst_q;
    assign PC_out    = pc_out_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: behavioural memory with programmable ack
// latency, delivery scoreboard, a vector table and hand-written corner sequences.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] PC_out;
    logic        valid_out;

    if_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_out   (inst_out),
        .PC_out     (PC_out),
        .valid_out  (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        int          lat;
        int          stall_cyc;
        logic [31:0] exp_addr;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[5];
    int          n_pass = 0;
    int          n_total = 0;
    int          mem_lat = 0;
    int          mem_cnt = 0;
    bit          req_active = 0;
    bit          squash_pending = 0;
    bit          prev_valid = 0;
    logic [31:0] req_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        return {a[23:0], 8'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // One clock cycle: memory responds to the current request, then outputs
    // are sampled on the following falling edge.
    task automatic tick();
        exp_t e;
        imem_ack = 1'b0;
        if (imem_req) begin
            if (!req_active) begin
                req_active = 1;
                req_addr   = imem_addr;
                mem_cnt    = 0;
            end else begin
                check("addr_stable", imem_addr, req_addr);
            end
            if (mem_cnt == mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                if (!squash_pending && !redirect) exp_q.push_back({imem_addr, imem_rdata});
                req_active     = 0;
                squash_pending = 0;
            end else begin
                mem_cnt++;
            end
        end else if (req_active) begin
            check("req_held", 32'(imem_req), 32'd1);
            req_active = 0;
        end
        prev_valid = valid_out;
        @(posedge clk);
        if (redirect && req_active) squash_pending = 1;
        @(negedge clk);
        imem_ack = 1'b0;
        redirect = 1'b0;
        if (valid_out && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: got pc %08h inst %08h required no delivery", PC_out, inst_out);
            end else begin
                e = exp_q.pop_front();
                $display("deliver pc=%08h inst=%08h", PC_out, inst_out);
                check("sb_pc", PC_out, e.pc);
                check("sb_inst", inst_out, e.inst);
            end
        end else if (!valid_out) begin
            check("nop_when_idle", inst_out, NOP);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{0, 0, 32'h0000_0004};
        vecs[1] = '{1, 0, 32'h0000_0008};
        vecs[2] = '{3, 4, 32'h0000_000C};
        vecs[3] = '{2, 1, 32'h0000_0010};
        vecs[4] = '{0, 2, 32'h0000_0014};

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_inst", inst_out, NOP);
        check("rst_pc_out", PC_out, 32'h0);
        rst = 1'b0;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);

        // Zero-wait first fetch
        mem_lat = 0;
        tick();
        check("zw_valid", 32'(valid_out), 32'd1);
        check("zw_inst", inst_out, 32'h0010_0093);
        check("zw_pc", PC_out, 32'h0);

        // Vector table: latency, stall duration in HOLD, expected fetch address
        for (int i = 0; i < 5; i++) begin
            tick();
            check("vec_req", 32'(imem_req), 32'd1);
            check("vec_addr", imem_addr, vecs[i].exp_addr);
            mem_lat = vecs[i].lat;
            stall   = (vecs[i].stall_cyc != 0);
            n = 0;
            while (!valid_out && n < 20) begin
                tick();
                n++;
            end
            check("vec_valid", 32'(valid_out), 32'd1);
            check("vec_pc", PC_out, vecs[i].exp_addr);
            check("vec_inst", inst_out, mem_word(vecs[i].exp_addr));
            for (int s = 0; s < vecs[i].stall_cyc; s++) begin
                tick();
                check("stall_valid", 32'(valid_out), 32'd1);
                check("stall_pc", PC_out, vecs[i].exp_addr);
                check("stall_noreq", 32'(imem_req), 32'd0);
            end
            stall = 1'b0;
        end
        tick();
        check("after_vec_addr", imem_addr, 32'h0000_0018);

        // Redirect while holding under stall
        mem_lat = 0;
        stall = 1'b1;
        tick();
        check("hold_valid", 32'(valid_out), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        check("rh_valid", 32'(valid_out), 32'd0);
        check("rh_inst", inst_out, NOP);
        check("rh_req", 32'(imem_req), 32'd1);
        check("rh_addr", imem_addr, 32'h0000_0100);
        stall = 1'b0;

        // Redirect in the first cycle of a slow request: old request held, data dropped
        mem_lat = 3;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        check("sq_addr", imem_addr, 32'h0000_0100);
        n = 0;
        while (imem_addr != 32'h0000_0200 && n < 20) begin
            check("sq_no_valid", 32'(valid_out), 32'd0);
            tick();
            n++;
        end
        check("sq_new_addr", imem_addr, 32'h0000_0200);
        mem_lat = 0;
        tick();
        check("sq_deliver_pc", PC_out, 32'h0000_0200);
        tick();
        check("next_addr", imem_addr, 32'h0000_0204);

        // Redirect coinciding with ack
        redirect = 1'b1; redirect_pc = 32'h0000_0400;
        tick();
        check("ra_valid", 32'(valid_out), 32'd0);
        check("ra_addr", imem_addr, 32'h0000_0400);

        // Wrap at top of address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wr_pc_out", PC_out, 32'hFFFF_FFFC);
        tick();
        check("wr_next", imem_addr, 32'h0000_0000);

        // Async reset while waiting for ack
        redirect = 1'b1; redirect_pc = 32'h0000_0500;
        tick();
        mem_lat = 5;
        tick();
        tick();
        check("pre_rst_addr", imem_addr, 32'h0000_0500);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(valid_out), 32'd0);
        check("arst_inst", inst_out, NOP);
        check("arst_pc", PC_out, 32'h0);
        exp_q.delete();
        req_active = 0; squash_pending = 0; mem_cnt = 0; prev_valid = 0;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        check("arst_ack_ignored", 32'(valid_out), 32'd0);
        rst = 1'b0;
        check("arst_req", 32'(imem_req), 32'd1);
        check("arst_addr", imem_addr, 32'h0);
        mem_lat = 0;
        tick();
        check("arst_deliver", inst_out, 32'h0010_0093);
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
